// File: rtl/ulpi_phy_responder.sv
// Behavioural ULPI PHY responder: accepts link TX packets and plays host-side RX packets
// onto the ULPI bus with turnaround, RX CMD and end-of-packet framing.
module ulpi_phy_responder #(
    parameter int          MAX_PKT      = 66,
    parameter logic [7:0]  RXCMD_ACTIVE = 8'h10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] ulpi_data_in,
    input  logic       stp,
    output logic [7:0] ulpi_data_out,
    output logic       dir,
    output logic       nxt,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_last,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_done,
    output logic [6:0] tx_count,
    output logic       err
);

    // state       | meaning
    // IDLE        | link owns the bus, waiting for TX CMD or host rx byte
    // TX_ACK      | TX CMD accepted (nxt high), first data byte follows
    // TX_DATA     | capturing link bytes until stp
    // RX_TURN     | bus turnaround towards the PHY
    // RX_CMD      | RX CMD with RxActive set
    // RX_DATA     | streaming host bytes, RX CMD on gaps
    // RX_EOP      | RX CMD with RxActive cleared
    // RX_END_TURN | bus turnaround back to the link
    typedef enum logic [2:0] {
        IDLE, TX_ACK, TX_DATA, RX_TURN, RX_CMD, RX_DATA, RX_EOP, RX_END_TURN
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_PKT);

    state_t     state, state_d;
    logic [6:0] cnt, cnt_d;
    logic [7:0] data_d, tx_data_d;
    logic [6:0] tx_count_d;
    logic       dir_d, nxt_d, tx_valid_d, tx_done_d, err_d;

    assign rx_ready = (state == RX_DATA) && rx_valid;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        dir_d      = 1'b0;
        nxt_d      = 1'b0;
        data_d     = 8'h00;
        tx_data_d  = tx_data;
        tx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_count_d = tx_count;
        err_d      = err;

        if (stp && (dir || state == IDLE))
            err_d = 1'b1;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_d = RX_TURN;
                    cnt_d   = 7'd0;
                end else if (!stp && ulpi_data_in[7:6] == 2'b01) begin
                    state_d = TX_ACK;
                    nxt_d   = 1'b1;
                    cnt_d   = 7'd0;
                end
            end
            TX_ACK, TX_DATA: begin
                if (stp) begin
                    state_d    = IDLE;
                    tx_done_d  = 1'b1;
                    tx_count_d = cnt;
                end else begin
                    state_d = TX_DATA;
                    nxt_d   = 1'b1;
                    // the TX_ACK cycle still carries the TX CMD byte, so only TX_DATA captures
                    if (state == TX_DATA) begin
                        if (cnt < MAX_CNT) begin
                            tx_data_d  = ulpi_data_in;
                            tx_valid_d = 1'b1;
                            cnt_d      = cnt + 7'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            RX_TURN: begin
                dir_d   = 1'b1;
                state_d = RX_CMD;
            end
            RX_CMD: begin
                dir_d   = 1'b1;
                data_d  = RXCMD_ACTIVE;
                state_d = RX_DATA;
            end
            RX_DATA: begin
                dir_d = 1'b1;
                if (rx_valid) begin
                    nxt_d  = 1'b1;
                    data_d = rx_data;
                    if (rx_last) begin
                        state_d = RX_EOP;
                    end else if (cnt >= MAX_CNT) begin
                        err_d   = 1'b1;
                        state_d = RX_EOP;
                    end else begin
                        cnt_d = cnt + 7'd1;
                    end
                end else begin
                    data_d = RXCMD_ACTIVE;
                end
            end
            RX_EOP: begin
                dir_d   = 1'b1;
                state_d = RX_END_TURN;
            end
            RX_END_TURN: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cnt           <= 7'd0;
            dir           <= 1'b0;
            nxt           <= 1'b0;
            ulpi_data_out <= 8'h00;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            tx_done       <= 1'b0;
            tx_count      <= 7'd0;
            err           <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            dir           <= dir_d;
            nxt           <= nxt_d;
            ulpi_data_out <= data_d;
            tx_data       <= tx_data_d;
            tx_valid      <= tx_valid_d;
            tx_done       <= tx_done_d;
            tx_count      <= tx_count_d;
            err           <= err_d;
        end
    end

endmodule

// File: doc/ulpi_phy_responder.md
ULPI_PHY_RESPONDER -- requirements
Module: ulpi_phy_responder

Interface
REQ-001 SHALL have parameter MAX_PKT, default 66, meaning maximum bytes per RX or TX packet (64 payload + 2 CRC).
REQ-002 SHALL have parameter RXCMD_ACTIVE, default 8'h10, meaning the RX CMD byte driven while RxActive=1.
REQ-003 SHALL have port clk, input, 1, the single clock; it also serves as the ULPI clock.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ulpi_data_in, input, 8, the link-driven ULPI data bus.
REQ-006 SHALL have port stp, input, 1, the link stop.
REQ-007 SHALL have port ulpi_data_out, output, 8, the PHY-driven ULPI data bus.
REQ-008 SHALL have port dir, output, 1, bus direction; 1 means the PHY owns the data bus.
REQ-009 SHALL have port nxt, output, 1, the PHY next/accept strobe.
REQ-010 SHALL have port rx_data, input, 8, a host-side byte to send to the link.
REQ-011 SHALL have port rx_valid, input, 1, rx_data is valid.
REQ-012 SHALL have port rx_last, input, 1, the rx_data byte is the final byte of its packet.
REQ-013 SHALL have port rx_ready, output, 1, the rx byte is consumed this cycle.
REQ-014 SHALL have port tx_data, output, 8, a byte captured from a link transmit.
REQ-015 SHALL have port tx_valid, output, 1, one-cycle pulse qualifying tx_data.
REQ-016 SHALL have port tx_done, output, 1, one-cycle pulse at the end of a link packet.
REQ-017 SHALL have port tx_count, output, 7, the number of data bytes in the last TX packet; valid at tx_done.
REQ-018 SHALL have port err, output, 1, a sticky protocol error flag.

Function
REQ-019 SHALL implement FSM states IDLE, TX_ACK, TX_DATA, RX_TURN, RX_CMD, RX_DATA, RX_EOP, RX_END_TURN.
REQ-020 SHALL register dir, nxt, ulpi_data_out, tx_data, tx_valid, tx_done, tx_count and err; rx_ready SHALL be combinational: (state==RX_DATA && rx_valid).
REQ-021 SHALL, in IDLE, hold dir=0, nxt=0 and ulpi_data_out=8'h00.
REQ-022 SHALL, in IDLE with rx_valid=1, go to RX_TURN; RX SHALL have priority over a simultaneous TX CMD, which is ignored.
REQ-023 SHALL, in IDLE with ulpi_data_in[7:6]==2'b01 and rx_valid=0, go to TX_ACK, drive nxt=1 in TX_ACK (accepting the TX CMD), and clear the byte counter.
REQ-024 SHALL, in TX_DATA, hold nxt=1; each cycle with stp=0 captures ulpi_data_in to tx_data, pulses tx_valid the next cycle and increments the counter.
REQ-025 SHALL, on stp=1 in TX_ACK or TX_DATA, not capture that cycle's data, pulse tx_done with tx_count=counter the next cycle, drive nxt=0 and return to IDLE.
REQ-026 SHALL, when the TX counter reaches MAX_PKT with stp still 0, set err, stop capturing, and keep nxt=1 until stp.
REQ-027 SHALL, in RX_TURN, drive dir=1, nxt=0 and data=8'h00 for exactly one cycle (turnaround), then go to RX_CMD.
REQ-028 SHALL, in RX_CMD, drive dir=1, nxt=0 and data=RXCMD_ACTIVE for one cycle, then go to RX_DATA.
REQ-029 SHALL, in RX_DATA with rx_valid=1, drive the next cycle dir=1, nxt=1 and data=rx_data; with rx_valid=0 (gap), it drives nxt=0 and data=RXCMD_ACTIVE.
REQ-030 SHALL, on an accepted byte with rx_last=1, go to RX_EOP, driving dir=1, nxt=0 and data=8'h00 (RxActive=0) for one cycle, then RX_END_TURN.
REQ-031 SHALL, in RX_END_TURN, drive dir=0, nxt=0 and data=8'h00 for one cycle, then IDLE.
REQ-032 SHALL, when the RX byte count exceeds MAX_PKT without rx_last, set err and go to RX_EOP.
REQ-033 SHALL set err on stp=1 while dir=1, or on stp=1 in IDLE, with no state change.
REQ-034 SHALL clear err only on reset.
REQ-035 SHALL size the counter to 7 bits, with no wrap beyond MAX_PKT.

Reset
REQ-036 SHALL, while n_rst=0, immediately force state=IDLE and dir, nxt, ulpi_data_out, tx_valid, tx_done, tx_count, err and the counter to 0, including mid-packet.
REQ-037 SHALL, after n_rst deasserts mid-packet, ignore the remaining bytes until a new TX CMD or rx_valid.

Verification
REQ-038 SHALL verify: TX CMD 8'h41, then 3 bytes 8'hA1/A2/A3, then stp -> nxt=1 from cycle 1; tx_valid x3 with the matching data; tx_done with tx_count=3; nxt=0 afterwards.
REQ-039 SHALL verify: rx packet 8'h2D, 8'h00, 8'h10 (last), all valid back-to-back -> dir rises, one turnaround cycle, 8'h10 with nxt=0, three bytes with nxt=1, 8'h00 EOP, one turnaround with dir=0.
REQ-040 SHALL verify: rx_valid and TX CMD asserted in the same IDLE cycle -> RX sequence runs and no tx_valid occurs.
REQ-041 SHALL verify: an rx_valid gap of 2 cycles mid-packet -> two cycles of nxt=0 with data=8'h10, and dir held at 1.
REQ-042 SHALL verify: a TX of 67 bytes without stp -> err=1 after byte 66, tx_count=66 at stp.
REQ-043 SHALL verify: n_rst pulsed low during RX_DATA -> dir=0 and nxt=0 immediately; err=0; the next packet is handled normally.
